// File: rtl/stock_weight_bank_if.sv
// Request/response channel of the stock weight bank: valid/ready in both directions.
// The master drives requests and consumes responses; the slave is the bank.
interface stock_weight_bank_if #(
  parameter int NUM_FEATURES = 5,
  parameter int FEAT_W       = 8,
  parameter int CMD_W        = 8,
  parameter int SEL_W        = 2
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [SEL_W-1:0]                     in_stock;
  logic [CMD_W+NUM_FEATURES*FEAT_W-1:0] in_data;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [SEL_W-1:0]                     out_stock;
  logic [NUM_FEATURES*FEAT_W-1:0]       out_data;

  modport master (
    output in_valid, in_stock, in_data, out_ready,
    input  in_ready, out_valid, out_stock, out_data
  );

  modport slave (
    input  in_valid, in_stock, in_data, out_ready,
    output in_ready, out_valid, out_stock, out_data
  );
endinterface

// File: rtl/stock_weight_bank.sv
// Per-stock weight store plus serial MAC buy/sell decision; 1 cycle to response (NUM_FEATURES+2 for CALC_BUY).
// One request in flight: in_ready only in IDLE, response held until out_ready.
module stock_weight_bank #(
  parameter int NUM_STOCKS   = 4,
  parameter int NUM_FEATURES = 5,
  parameter int FEAT_W       = 8,
  parameter int CMD_W        = 8,
  parameter int SEL_W        = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  stock_weight_bank_if.slave   bus
);

  localparam int DW    = NUM_FEATURES * FEAT_W;
  localparam int IDX_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
  localparam int FI_W  = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int ACC_W = 2 * FEAT_W + $clog2(NUM_FEATURES) + 1;
  localparam int WS_W  = FEAT_W + $clog2(NUM_FEATURES) + 1;

  localparam logic [CMD_W-1:0] CMD_SET   = CMD_W'(8'h0A);
  localparam logic [CMD_W-1:0] CMD_GET   = CMD_W'(8'h0B);
  localparam logic [CMD_W-1:0] CMD_CALC  = CMD_W'(8'h0C);
  localparam logic [CMD_W-1:0] CMD_POS   = CMD_W'(8'h0D);
  localparam logic [CMD_W-1:0] CMD_NEG   = CMD_W'(8'h0E);
  localparam logic [CMD_W-1:0] CMD_CLEAR = CMD_W'(8'h0F);

  typedef enum logic [1:0] {IDLE, MAC, CMP, RESP} state_t;

  function automatic logic [DW-1:0] resp_word(input logic [3:0] nib);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < DW / 4; i++) w[i*4 +: 4] = nib;
    return w;
  endfunction

  function automatic logic [FEAT_W-1:0] sat_add(input logic [FEAT_W-1:0] a, input logic [FEAT_W-1:0] b);
    logic [FEAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[FEAT_W] ? {FEAT_W{1'b1}} : s[FEAT_W-1:0];
  endfunction

  function automatic logic [FEAT_W-1:0] sat_sub(input logic [FEAT_W-1:0] a, input logic [FEAT_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  state_t              state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [DW-1:0]       out_data_q;
  logic [SEL_W-1:0]    out_stock_q;
  logic [FEAT_W-1:0]   weights_q [NUM_STOCKS][NUM_FEATURES];
  logic [FEAT_W-1:0]   feat_q    [NUM_FEATURES];
  logic [IDX_W-1:0]    stock_q;
  logic [FI_W-1:0]     idx_q;
  logic [ACC_W-1:0]    acc_q;
  logic [WS_W-1:0]     wsum_q;

  logic [CMD_W-1:0]    cmd;
  logic [IDX_W-1:0]    sel;
  logic                stock_ok;
  logic                cmd_ok;
  logic                accept;
  logic                wr_en;
  logic [FEAT_W-1:0]   feat_in [NUM_FEATURES];
  logic [FEAT_W-1:0]   w_d     [NUM_FEATURES];
  logic [DW-1:0]       rd_word;
  logic [DW-1:0]       resp_d;

  always_comb begin
    cmd      = bus.in_data[DW +: CMD_W];
    sel      = IDX_W'(bus.in_stock);
    stock_ok = 32'(bus.in_stock) < NUM_STOCKS;
    cmd_ok   = cmd inside {CMD_SET, CMD_GET, CMD_CALC, CMD_POS, CMD_NEG, CMD_CLEAR};
    accept   = bus.in_valid && in_ready_q;
    wr_en    = accept && stock_ok && (cmd inside {CMD_SET, CMD_POS, CMD_NEG, CMD_CLEAR});
    rd_word  = '0;
    for (int f = 0; f < NUM_FEATURES; f++) begin
      feat_in[f] = bus.in_data[f*FEAT_W +: FEAT_W];
      rd_word[f*FEAT_W +: FEAT_W] = weights_q[sel][f];
      w_d[f] = weights_q[sel][f];
      case (cmd)
        CMD_SET:   w_d[f] = feat_in[f];
        CMD_POS:   w_d[f] = sat_add(weights_q[sel][f], feat_in[f]);
        CMD_NEG:   w_d[f] = sat_sub(weights_q[sel][f], feat_in[f]);
        CMD_CLEAR: w_d[f] = '0;
        default:   w_d[f] = weights_q[sel][f];
      endcase
    end
    if (!(stock_ok && cmd_ok)) resp_d = resp_word(4'hE);
    else if (cmd == CMD_GET)   resp_d = rd_word;
    else                       resp_d = resp_word(4'hC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_stock_q <= '0;
      stock_q     <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      wsum_q      <= '0;
      for (int s = 0; s < NUM_STOCKS; s++)
        for (int f = 0; f < NUM_FEATURES; f++) weights_q[s][f] <= '0;
      for (int f = 0; f < NUM_FEATURES; f++) feat_q[f] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            in_ready_q  <= 1'b0;
            out_stock_q <= bus.in_stock;
            if (wr_en)
              for (int f = 0; f < NUM_FEATURES; f++) weights_q[sel][f] <= w_d[f];
            if (stock_ok && cmd == CMD_CALC) begin
              stock_q <= sel;
              feat_q  <= feat_in;
              acc_q   <= '0;
              wsum_q  <= '0;
              idx_q   <= '0;
              state_q <= MAC;
            end else begin
              out_data_q <= resp_d;
              state_q    <= RESP;
            end
          end
        end
        MAC: begin
          acc_q  <= acc_q + ACC_W'(weights_q[stock_q][idx_q]) * ACC_W'(feat_q[idx_q]);
          wsum_q <= wsum_q + WS_W'(weights_q[stock_q][idx_q]);
          idx_q  <= idx_q + FI_W'(1);
          if (idx_q == FI_W'(NUM_FEATURES - 1)) state_q <= CMP;
        end
        CMP: begin
          // Strict compare: a tie against half the weight sum is a SELL.
          out_data_q <= (acc_q > ACC_W'(wsum_q >> 1)) ? resp_word(4'h1) : resp_word(4'h2);
          state_q    <= RESP;
        end
        RESP: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_stock = out_stock_q;

endmodule
